// File: rtl/core_fetch_pc_if.sv
// core_fetch_pc_if: bundle of the fetch stage's external signals.
//   Redirect in : pc_new_valid, pc_new
//   Memory      : imem_req_valid/ready/addr (request), imem_rsp_valid/data/err (response)
//   Decode      : if_valid/ready (handshake), if_pc, if_instr, if_fault
// master = the fetch unit, slave = its environment (execute, memory, decode).
interface core_fetch_pc_if;
  logic        pc_new_valid;
  logic [31:0] pc_new;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  modport master (
    input  pc_new_valid, pc_new, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault
  );

  modport slave (
    output pc_new_valid, pc_new, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_fault
  );
endinterface

// File: rtl/core_fetch_pc.sv
// core_fetch_pc: fetch-stage PC sequencer. Owns the fetch PC, issues one
// outstanding instruction-memory request at a time, discards responses made
// stale by an execute redirect and presents instructions to decode.
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : core_fetch_pc_if.master (redirect, imem request/response, decode)
// Optional feature: define CORE_FETCH_MISALIGN_EN to turn a misaligned
// redirect target into an instruction fault delivered without a memory access.
module core_fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  core_fetch_pc_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t      state_q, state_seq, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] if_pc_q, if_instr_q;
  logic        if_fault_q;
  logic        redirect;
  logic [31:0] redir_target;
  logic        mis_next;
  logic        fault_entry;
  logic        cap_rsp;

  // A redirect during the single IDLE cycle is ignored so the reset-PC fetch proceeds.
  assign redirect = bus.pc_new_valid && (state_q != S_IDLE);

`ifdef CORE_FETCH_MISALIGN_EN
  logic mis_pend_q;

  assign redir_target = bus.pc_new;
  assign mis_next     = redirect ? (bus.pc_new[1:0] != 2'b00) : mis_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_pend_q <= 1'b0;
    else     mis_pend_q <= mis_next && !fault_entry;
  end
`else
  assign redir_target = {bus.pc_new[31:2], 2'b00};
  assign mis_next     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_seq = state_q;
    if (redirect) begin
      // Anything already accepted by memory must have its response drained in KILL.
      if ((state_q == S_REQ  && bus.imem_req_ready) ||
          (state_q == S_WAIT && !bus.imem_rsp_valid) ||
          (state_q == S_KILL && !bus.imem_rsp_valid))
        state_seq = S_KILL;
      else
        state_seq = S_REQ;
    end else begin
      case (state_q)
        S_IDLE:  state_seq = S_REQ;
        S_REQ:   if (bus.imem_req_ready) state_seq = S_WAIT;
        S_WAIT:  if (bus.imem_rsp_valid) state_seq = S_HOLD;
        S_HOLD:  if (bus.if_ready)       state_seq = S_REQ;
        S_KILL:  if (bus.imem_rsp_valid) state_seq = S_REQ;
        default: state_seq = S_IDLE;
      endcase
    end
  end

  // A pending misaligned PC is delivered as a fault in place of the request.
  assign fault_entry = mis_next && (state_seq == S_REQ);
  assign state_d     = fault_entry ? S_HOLD : state_seq;
  assign cap_rsp     = !redirect && (state_q == S_WAIT) && bus.imem_rsp_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = redir_target;
    else if (state_q == S_HOLD && bus.if_ready)
      fetch_pc_d = (fetch_pc_q + 32'd4) & ~32'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
      if_fault_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (cap_rsp) begin
        if_pc_q    <= fetch_pc_q;
        if_instr_q <= bus.imem_rsp_err ? 32'd0 : bus.imem_rsp_data;
        if_fault_q <= bus.imem_rsp_err;
      end else if (fault_entry) begin
        if_pc_q    <= fetch_pc_d;
        if_instr_q <= 32'd0;
        if_fault_q <= 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.imem_req_valid = (state_q == S_REQ);
    bus.imem_req_addr  = fetch_pc_q;
    bus.if_valid       = (state_q == S_HOLD);
    bus.if_pc          = if_pc_q;
    bus.if_instr       = if_instr_q;
    bus.if_fault       = if_fault_q;
  end

endmodule

// File: doc/core_fetch_pc.md
# core_fetch_pc

Fetch-stage PC sequencer and instruction fetcher that consumes the execute-stage redirect pair (`pc_new_valid`/`pc_new`). It owns the architectural fetch PC, issues single-outstanding requests to instruction memory, discards responses made stale by a redirect, and presents fetched instructions to decode over a valid/ready handshake.

## Interface
- `RESET_PC`, 32'h8000_0000, fetch PC after reset

- `clk` in 1, core clock
- `rst` in 1, asynchronous active-high reset
- `pc_new_valid` in 1, redirect strobe from execute, single-cycle
- `pc_new` in 32, redirect target, meaningful only when `pc_new_valid`=1
- `imem_req_valid` out 1, fetch request valid
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out 32, fetch address, word aligned
- `imem_rsp_valid` in 1, response strobe, one per accepted request
- `imem_rsp_data` in 32, instruction word
- `imem_rsp_err` in 1, access fault on this response
- `if_valid` out 1, instruction available to decode
- `if_ready` in 1, decode accepts
- `if_pc` out 32, PC of presented instruction
- `if_instr` out 32, instruction word; 0 when `if_fault`=1
- `if_fault` out 1, instruction access fault or misaligned fetch

## Operation
- Registers: `fetch_pc` (32), state, output register (`if_pc`, `if_instr`, `if_fault`), `mis_pend` (macro only).
- States: IDLE (reset), REQ, WAIT, HOLD, KILL.
- IDLE: unconditionally go to REQ.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`. On `imem_req_ready`, go to WAIT.
- WAIT: on `imem_rsp_valid`, capture `fetch_pc`, data and err into the output register, then go to HOLD. When err=1, capture instr as 0.
- HOLD: `if_valid`=1. On `if_ready`, `fetch_pc` <= `fetch_pc`+4 (mod 2^32) and go to REQ.
- KILL: one accepted request is outstanding and its response is stale. On `imem_rsp_valid`, drop the response and go to REQ.
- Redirect (`pc_new_valid`=1) takes priority over everything in every state except IDLE:
  - `fetch_pc` <= {`pc_new`[31:2], 2'b00}.
  - Any held instruction is dropped. `if_valid`=0 from the next cycle.
  - From WAIT with no response this cycle, from REQ with a handshake this cycle, or from KILL with no response this cycle: go to KILL.
  - Otherwise go to REQ. This covers WAIT with a response this cycle, and KILL with a response this cycle; that response is discarded.
  - If redirect and the `if_valid`&`if_ready` handshake occur in the same cycle, decode still takes the instruction, but `fetch_pc` takes the redirect target, not +4.
- The request address may change while `imem_req_valid`=1 and not yet accepted, but only because of a redirect. Instruction memory tolerates this. Otherwise valid and address hold stable until ready.
- At most one request is outstanding at any time.
- A redirect in IDLE is ignored; reset PC fetch proceeds.

## Timing
- Reset values: state IDLE; `fetch_pc`=`RESET_PC`; `imem_req_valid`=0; `if_valid`=0; `if_pc`=0; `if_instr`=0; `if_fault`=0; `mis_pend`=0.
- First request is asserted in the 1st cycle after `rst` deasserts.
- If the request is accepted in cycle N and the response arrives in cycle M≥N+1, then `if_valid`=1 from cycle M+1.
- After the decode handshake in cycle K, the next request is asserted in cycle K+1.
- After a redirect in cycle R with nothing outstanding, a request to the new target is asserted in cycle R+1.
- Best case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- A zero-latency response (same cycle as acceptance) is not supported; memory responds at least 1 cycle after acceptance.
- `rst` mid-operation: all state returns to reset values immediately. An outstanding memory response arriving after reset is not tracked; the memory is reset by the same `rst`.

## Configuration
- `CORE_FETCH_MISALIGN_EN` defined:
  - A redirect with `pc_new`[1:0]≠0 sets `mis_pend` and loads `fetch_pc` with the unmasked `pc_new`.
  - When the state would next enter REQ, it enters HOLD instead, with `if_pc`=`fetch_pc`, `if_fault`=1, `if_instr`=0, and issues no memory request. `mis_pend` then clears.
  - On acceptance, sequencing continues at `fetch_pc`+4 masked to word alignment.
  - An aligned redirect clears `mis_pend`.
- `CORE_FETCH_MISALIGN_EN` undefined: `pc_new`[1:0] is ignored (forced 0), `mis_pend` does not exist, and no misalignment fault is ever raised.

## Test plan
- Reset release, memory ready=1, 2-cycle response latency, `if_ready`=1 → requests to 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, with matching `if_pc`/`if_instr`.
- Redirect to 0x0000_1000 in the cycle after acceptance of 0x8000_0004, with the response 3 cycles later → response dropped, never shown on `if_valid`; next request is 0x0000_1000 after the stale response.
- Redirect to 0x2000 in the same cycle as the WAIT response → response dropped; request 0x2000 the next cycle; no KILL.
- HOLD with `if_ready`=0 for 5 cycles, then redirect to 0x3000 → `if_valid` drops the next cycle and the next request is 0x3000. Separately, redirect together with the handshake → instruction consumed and next request is 0x3000, not pc+4.
- `imem_rsp_err`=1 on a fetch of 0x8000_0010 → `if_fault`=1, `if_instr`=0, `if_pc`=0x8000_0010; after the handshake the next request is 0x8000_0014.
- With the macro, redirect to 0x4002 → no request issued; `if_valid`=1, `if_fault`=1, `if_pc`=0x4002; after the handshake the next request is 0x4004. Without the macro → request 0x4000 and no fault.
